// File: rtl/ksa_seq_ctrl.sv
// Two-requester sequencer around one 8-bit Kogge-Stone adder: round-robin grant, LSB-first byte chaining.
// Optional subtract mode (req0_sub/req1_sub ports) is built when KSA_SUB_EN is defined.

module ksa_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       carry
);
  // One prefix level: merge each (g,p) pair with the pair d bits below it.
  function automatic logic [15:0] ks_level(input logic [7:0] g, input logic [7:0] p, input int d);
    logic [7:0] g_n;
    logic [7:0] p_n;
    g_n = g;
    p_n = p;
    for (int i = 0; i < 8; i++) begin
      if (i >= d) begin
        g_n[i] = g[i] | (p[i] & g[i-d]);
        p_n[i] = p[i] & p[i-d];
      end
    end
    return {g_n, p_n};
  endfunction

  logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [8:0] c;

  assign g0 = a & b;
  assign p0 = a ^ b;
  assign {g1, p1} = ks_level(g0, p0, 1);
  assign {g2, p2} = ks_level(g1, p1, 2);
  assign {g3, p3} = ks_level(g2, p2, 4);

  assign c     = {g3 | (p3 & {8{cin}}), cin};
  assign sum   = p0 ^ c[7:0];
  assign carry = c[8];
endmodule

module ksa_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [8*NBYTES-1:0]   req0_a,
  input  logic [8*NBYTES-1:0]   req0_b,
  input  logic                  req0_cin,
`ifdef KSA_SUB_EN
  input  logic                  req0_sub,
`endif
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [8*NBYTES-1:0]   req1_a,
  input  logic [8*NBYTES-1:0]   req1_b,
  input  logic                  req1_cin,
`ifdef KSA_SUB_EN
  input  logic                  req1_sub,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [8*NBYTES-1:0]   rsp_sum,
  output logic                  rsp_cout
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d, cin_q, cin_d, id_q, id_d;
  logic            last_q, last_d, cout_q, cout_d, valid_q, valid_d;
  logic            op_sub;
`ifdef KSA_SUB_EN
  logic            sub_q, sub_d;
  assign op_sub = sub_q;
`else
  assign op_sub = 1'b0;
`endif

  logic       grant0, grant1, sel1, load;
  logic [7:0] a_byte, b_byte, k_sum;
  logic       k_cin, k_carry;

  // Tie goes to the requester that was not served last.
  assign grant0     = req0_valid & (~req1_valid | last_q);
  assign grant1     = req1_valid & (~req0_valid | ~last_q);
  assign req0_ready = rst_n & (state_q == IDLE) & grant0;
  assign req1_ready = rst_n & (state_q == IDLE) & grant1;
  assign sel1       = req1_ready;
  assign load       = req0_ready | req1_ready;

  assign a_byte = 8'(a_q >> (8 * idx_q));
  assign b_byte = op_sub ? ~8'(b_q >> (8 * idx_q)) : 8'(b_q >> (8 * idx_q));
  assign k_cin  = (idx_q == '0) ? (op_sub | cin_q) : carry_q;

  ksa_8 u_ksa (
    .a     (a_byte),
    .b     (b_byte),
    .cin   (k_cin),
    .sum   (k_sum),
    .carry (k_carry)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cin_d   = cin_q;
    id_d    = id_q;
    last_d  = last_q;
    cout_d  = cout_q;
    valid_d = valid_q;
`ifdef KSA_SUB_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          a_d     = sel1 ? req1_a : req0_a;
          b_d     = sel1 ? req1_b : req0_b;
          cin_d   = sel1 ? req1_cin : req0_cin;
`ifdef KSA_SUB_EN
          sub_d   = sel1 ? req1_sub : req0_sub;
`endif
          id_d    = sel1;
          last_d  = sel1;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) sum_d[8*i +: 8] = k_sum;
        end
        carry_d = k_carry;
        idx_d   = IW'(idx_q + 1'b1);
        if (idx_q == IW'(NBYTES - 1)) begin
          cout_d  = k_carry;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cin_q   <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef KSA_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cin_q   <= cin_d;
      id_q    <= id_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
`ifdef KSA_SUB_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
endmodule

// File: tb/tb_ksa_seq_ctrl.sv
// Self-checking bench for ksa_seq_ctrl (NBYTES=4): directed vectors, round-robin, backpressure,
// mid-operation reset and randomized traffic against an arithmetic reference model.

module tb_ksa_seq_ctrl;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req0_cin, req0_sub;
  logic         req1_valid, req1_ready, req1_cin, req1_sub;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [W-1:0] rsp_sum;

  int   errors = 0;
  int   checks = 0;
  logic model_last;

  always #5 clk = ~clk;

  ksa_seq_ctrl #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
`ifdef KSA_SUB_EN
    .req0_sub   (req0_sub),
`endif
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
`ifdef KSA_SUB_EN
    .req1_sub   (req1_sub),
`endif
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout)
  );

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic; subtract is A + ~B + 1.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic cin, input logic sub);
    if (sub) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  function automatic logic rnd_sub();
`ifdef KSA_SUB_EN
    return 1'($urandom);
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub);
    if (r == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; req0_sub = sub;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; req1_sub = sub;
    end
  endtask

  // Called at a negedge in IDLE with requests already driven; returns at a negedge after release.
  task automatic serve(input bit drop, input int hold, output logic [W-1:0] s, output logic co);
    logic         eid, ecin, esub;
    logic [W-1:0] ea, eb;
    logic [W:0]   exp;
    int           lat;
    rsp_ready = (hold == 0);
    #1;
    eid = (req0_valid && req1_valid) ? ~model_last : req1_valid;
    chk("grant", {req1_ready, req0_ready}, eid ? 2 : 1);
    ea   = eid ? req1_a : req0_a;
    eb   = eid ? req1_b : req0_b;
    ecin = eid ? req1_cin : req0_cin;
    esub = eid ? req1_sub : req0_sub;
    @(posedge clk);
    model_last = eid;
    #1;
    // Scramble the accepted requester's operands to prove they were latched.
    if (eid) begin
      req1_a = $urandom; req1_b = $urandom; req1_cin = 1'($urandom); req1_sub = rnd_sub();
      if (drop) req1_valid = 1'b0;
    end else begin
      req0_a = $urandom; req0_b = $urandom; req0_cin = 1'($urandom); req0_sub = rnd_sub();
      if (drop) req0_valid = 1'b0;
    end
    exp = model(ea, eb, ecin, esub);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!rsp_valid) chk("busy_ready", {req1_ready, req0_ready}, 0);
    end while (!rsp_valid && lat < 30);
    chk("latency", lat, NB + 1);
    s  = rsp_sum;
    co = rsp_cout;
    chk("sum", rsp_sum, exp[W-1:0]);
    chk("cout", rsp_cout, exp[W]);
    chk("id", rsp_id, eid);
    chk("done_ready", {req1_ready, req0_ready}, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_sum", rsp_sum, s);
      chk("hold_cout", rsp_cout, co);
      chk("hold_id", rsp_id, eid);
      chk("hold_ready", {req1_ready, req0_ready}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("released", rsp_valid, 0);
    $display("op id=%0d a=%h b=%h cin=%0d sub=%0d sum=%h cout=%0d lat=%0d hold=%0d",
             eid, ea, eb, ecin, esub, s, co, lat, hold);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] s;
    logic         co;
    logic [W-1:0] pa [4] = '{32'h0000_0000, 32'h0000_00FF, 32'hFFFF_FFFF, 32'hEAEA_EAEA};
    logic [W-1:0] pb [4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'hD5D5_D5D5};
    logic         pc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] ps [4] = '{32'h0000_0001, 32'h0000_0100, 32'h0000_0000, 32'hC0C0_C0BF};
    logic         po [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sub = 1'b0;
    model_last = 1'b1;

    // Reset state, with both requesters already asking.
    set_req(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    set_req(1, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_cout", rsp_cout, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);

    // First tie goes to req0; its response is held off for several cycles.
    rst_n = 1'b1;
    serve(1'b1, 3, s, co);
    serve(1'b1, 0, s, co);

    // Directed carry-chain vectors on req0.
    for (int i = 0; i < 4; i++) begin
      set_req(0, pa[i], pb[i], pc[i], 1'b0);
      serve(1'b1, 0, s, co);
      chk("plan_sum", s, ps[i]);
      chk("plan_cout", co, po[i]);
    end

`ifdef KSA_SUB_EN
    set_req(0, 32'd5, 32'd7, 1'b0, 1'b1);
    serve(1'b1, 0, s, co);
    chk("sub_sum_neg", s, 32'hFFFF_FFFE);
    chk("sub_cout_neg", co, 0);
    set_req(0, 32'd7, 32'd5, 1'b1, 1'b1);
    serve(1'b1, 0, s, co);
    chk("sub_sum_pos", s, 32'h0000_0002);
    chk("sub_cout_pos", co, 1);
    set_req(1, 32'd10, 32'd20, 1'b1, 1'b0);
    serve(1'b1, 0, s, co);
    chk("add_cin_sum", s, 32'd31);
`endif

    // Reset after two CALC edges of an in-flight op.
    set_req(0, 32'hDEAD_BEEF, 32'h0102_0304, 1'b0, 1'b0);
    #1;
    chk("mid_grant", req0_ready, 1);
    @(posedge clk);
    #1 req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    model_last = 1'b1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", {req1_ready, req0_ready}, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    set_req(1, 32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0);
    set_req(0, $urandom, $urandom, 1'($urandom), 1'b0);
    serve(1'b1, 0, s, co);
    serve(1'b1, 0, s, co);
    chk("post_rst_req1_sum", s, 32'h0303_0303);

    // Both requesters saturating: grants must alternate 0,1,0,1.
    set_req(0, $urandom, $urandom, 1'($urandom), rnd_sub());
    set_req(1, $urandom, $urandom, 1'($urandom), rnd_sub());
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_order", {req1_ready, req0_ready}, (i % 2 == 0) ? 1 : 2);
      serve(1'b0, 0, s, co);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Randomized traffic with occasional backpressure.
    for (int i = 0; i < 12; i++) begin
      if (!req0_valid && $urandom_range(0, 1) == 1)
        set_req(0, $urandom, $urandom, 1'($urandom), rnd_sub());
      if (!req1_valid && $urandom_range(0, 1) == 1)
        set_req(1, $urandom, $urandom, 1'($urandom), rnd_sub());
      if (!req0_valid && !req1_valid)
        set_req(0, $urandom, $urandom, 1'($urandom), rnd_sub());
      serve(1'b1, $urandom_range(0, 2), s, co);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
